// File: rtl/output_seg_display.sv
// Time-multiplexed 4-digit 7-segment driver with double-buffered load and registered pins.
// Optional leading-zero blanking when OUTPUT_SEG_LZB_EN is defined.
module output_seg_display #(
    parameter int unsigned DIV  = 100000,
    parameter int unsigned DEAD = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  en,
    output logic        busy,
    output logic        frame,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp_n
);

    localparam int unsigned    CntW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] DeadCnt = CntW'(DEAD);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [15:0]     pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [3:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [3:0]      pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic            busy_q, busy_d;
    logic            frame_q, frame_d;
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_n_q, dp_n_d;

    logic            tick, commit, lit;
    logic [3:0]      nibble;
    logic [3:0]      lzb;

`ifdef OUTPUT_SEG_LZB_EN
    // A digit goes dark only when it and everything above it is zero and its dp is off.
    logic z3, z2, z1;
    always_comb begin
        z3     = (act_data_q[15:12] == 4'h0);
        z2     = z3 && (act_data_q[11:8] == 4'h0);
        z1     = z2 && (act_data_q[7:4] == 4'h0);
        lzb    = 4'b0000;
        lzb[3] = z3 && !act_dp_q[3];
        lzb[2] = z2 && !act_dp_q[2];
        lzb[1] = z1 && !act_dp_q[1];
    end
`else
    assign lzb = 4'b0000;
`endif

    always_comb begin
        tick   = (cnt_q == CntMax);
        commit = tick && (digit_q == 2'd3);
        nibble = act_data_q[{digit_q, 2'b00} +: 4];

        cnt_d   = tick ? '0 : cnt_q + CntW'(1);
        digit_d = tick ? digit_q + 2'd1 : digit_q;

        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_en_d   = pend_en_q;
        if (load) begin
            pend_data_d = data;
            pend_dp_d   = dp;
            pend_en_d   = en;
        end

        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        if (commit) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_en_d   = pend_en_q;
        end

        // A load landing on the commit cycle keeps the buffer busy for another frame.
        if (load) begin
            busy_d = 1'b1;
        end else if (commit) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        frame_d = commit;

        lit     = (cnt_q >= DeadCnt) && act_en_q[digit_q] && !lzb[digit_q];
        anode_d = 4'hF;
        seg_d   = 7'h7F;
        dp_n_d  = 1'b1;
        if (lit) begin
            anode_d = ~(4'b0001 << digit_q);
            seg_d   = ~hex7(nibble);
            dp_n_d  = ~act_dp_q[digit_q];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q       <= '0;
            digit_q     <= 2'd0;
            pend_data_q <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_en_q   <= 4'h0;
            act_data_q  <= 16'h0000;
            act_dp_q    <= 4'h0;
            act_en_q    <= 4'h0;
            busy_q      <= 1'b0;
            frame_q     <= 1'b0;
            anode_q     <= 4'hF;
            seg_q       <= 7'h7F;
            dp_n_q      <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_en_q   <= pend_en_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
        end
    end

    assign busy  = busy_q;
    assign frame = frame_q;
    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp_n  = dp_n_q;

endmodule

// File: tb/tb_output_seg_display.sv
// Table-driven bench for output_seg_display (DIV=8, DEAD=2), plus load-ordering and reset sequences.
module tb_output_seg_display;

    logic        Clock;
    logic        Reset;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        busy;
    logic        frame;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp_n;

    int errors = 0;
    int checks = 0;

    output_seg_display #(
        .DIV  (8),
        .DEAD (2)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .load  (load),
        .data  (data),
        .dp    (dp),
        .en    (en),
        .busy  (busy),
        .frame (frame),
        .anode (anode),
        .seg   (seg),
        .dp_n  (dp_n)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // seg holds {d3,d2,d1,d0}; 7F marks a dark digit. dpn is {d3..d0} when lit.
    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Entered at a frame point; load v, check busy, end at the commit frame point.
    task automatic load_frame(input vec_t v, input string tag);
        data = v.data;
        dp   = v.dp;
        en   = v.en;
        load = 1'b1;
        step();
        load = 1'b0;
        chk({tag, " busy_set"}, 32'(busy), 32'd1);
        for (int t = 2; t <= 32; t++) begin
            step();
        end
        chk({tag, " commit_frame"}, 32'(frame), 32'd1);
        chk({tag, " busy_clr"}, 32'(busy), 32'd0);
    endtask

    // Entered at a frame point; check 32 cycles of pins against v.
    task automatic show_frame(input vec_t v, input logic hold, input string tag);
        int s, j;
        logic on;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        for (int t = 1; t <= 32; t++) begin
            step();
            s  = (t - 1) / 8;
            j  = (t - 1) % 8;
            on = (v.seg[s] != 7'h7F) && (j >= 2);
            ea = on ? ~(4'b0001 << s) : 4'hF;
            es = on ? v.seg[s] : 7'h7F;
            ed = on ? v.dpn[s] : 1'b1;
            chk($sformatf("%s t=%0d pins", tag, t), {20'h0, anode, seg, dp_n},
                {20'h0, ea, es, ed});
            chk($sformatf("%s t=%0d frame", tag, t), 32'(frame), 32'(t == 32));
            chk($sformatf("%s t=%0d busy", tag, t), 32'(busy), 32'(hold && (t != 32)));
        end
    endtask

    vec_t vecs[7];
    vec_t va, vb, vc;
    int   n;

    initial begin
        vecs[0] = '{data: 16'h12AF, dp: 4'b0100, en: 4'hF,
                    seg: {7'h79, 7'h24, 7'h08, 7'h0E}, dpn: 4'b1011};
        vecs[1] = '{data: 16'h3456, dp: 4'b1111, en: 4'b0101,
                    seg: {7'h7F, 7'h19, 7'h7F, 7'h02}, dpn: 4'b1010};
        vecs[2] = '{data: 16'h8CDE, dp: 4'b0001, en: 4'hF,
                    seg: {7'h00, 7'h46, 7'h21, 7'h06}, dpn: 4'b1110};
`ifdef OUTPUT_SEG_LZB_EN
        vecs[3] = '{data: 16'h0005, dp: 4'b0000, en: 4'hF,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h12}, dpn: 4'b1111};
        vecs[4] = '{data: 16'h0000, dp: 4'b0000, en: 4'hF,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, dpn: 4'b1111};
        vecs[5] = '{data: 16'h0070, dp: 4'b0100, en: 4'hF,
                    seg: {7'h7F, 7'h40, 7'h78, 7'h40}, dpn: 4'b1011};
`else
        vecs[3] = '{data: 16'h0005, dp: 4'b0000, en: 4'hF,
                    seg: {7'h40, 7'h40, 7'h40, 7'h12}, dpn: 4'b1111};
        vecs[4] = '{data: 16'h0000, dp: 4'b0000, en: 4'hF,
                    seg: {7'h40, 7'h40, 7'h40, 7'h40}, dpn: 4'b1111};
        vecs[5] = '{data: 16'h0070, dp: 4'b0100, en: 4'hF,
                    seg: {7'h40, 7'h40, 7'h78, 7'h40}, dpn: 4'b1011};
`endif
        vecs[6] = '{data: 16'h9B31, dp: 4'b1010, en: 4'hF,
                    seg: {7'h10, 7'h03, 7'h30, 7'h79}, dpn: 4'b0101};
        va = '{data: 16'h1111, dp: 4'b0000, en: 4'hF,
               seg: {7'h79, 7'h79, 7'h79, 7'h79}, dpn: 4'b1111};
        vb = '{data: 16'h2345, dp: 4'b0000, en: 4'hF,
               seg: {7'h24, 7'h30, 7'h19, 7'h12}, dpn: 4'b1111};
        vc = '{data: 16'h6789, dp: 4'b0000, en: 4'hF,
               seg: {7'h02, 7'h78, 7'h00, 7'h10}, dpn: 4'b1111};

        Reset = 1'b0;
        load  = 1'b0;
        data  = 16'h0000;
        dp    = 4'h0;
        en    = 4'h0;
        repeat (3) step();
        chk("reset pins", {20'h0, anode, seg, dp_n}, {20'h0, 4'hF, 7'h7F, 1'b1});
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame", 32'(frame), 32'd0);
        Reset = 1'b1;

        n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < 100);
        chk("first frame latency", 32'(n), 32'd32);

        for (int i = 0; i < 7; i++) begin
            load_frame(vecs[i], $sformatf("vec%0d", i));
            show_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Two loads before commit: last wins. Third load on the commit cycle.
        data = va.data; dp = va.dp; en = va.en; load = 1'b1;
        step();
        data = vb.data; dp = vb.dp; en = vb.en;
        step();
        load = 1'b0;
        chk("dbl busy", 32'(busy), 32'd1);
        for (int t = 3; t <= 31; t++) begin
            step();
        end
        data = vc.data; dp = vc.dp; en = vc.en; load = 1'b1;
        step();
        load = 1'b0;
        chk("commit-load frame", 32'(frame), 32'd1);
        chk("commit-load busy", 32'(busy), 32'd1);
        show_frame(vb, 1'b1, "showB");
        show_frame(vc, 1'b0, "showC");

        // Reset asserted while a digit is lit and the buffer is busy.
        data = vecs[0].data; dp = vecs[0].dp; en = vecs[0].en; load = 1'b1;
        step();
        load = 1'b0;
        repeat (4) step();
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset anode", 32'(anode), 32'(4'b1110));
        #2 Reset = 1'b0;
        #1;
        chk("async reset pins", {20'h0, anode, seg, dp_n}, {20'h0, 4'hF, 7'h7F, 1'b1});
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset frame", 32'(frame), 32'd0);
        repeat (3) begin
            step();
            chk("held reset pins", {20'h0, anode, seg, dp_n}, {20'h0, 4'hF, 7'h7F, 1'b1});
        end
        Reset = 1'b1;
        repeat (3) begin
            step();
            chk("post reset pins", {20'h0, anode, seg, dp_n}, {20'h0, 4'hF, 7'h7F, 1'b1});
            chk("post reset busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
